// File: rtl/cga_vram_pkg.sv
// Shared types and widths for the CGA video RAM arbiter and its address mapper.
package cga_vram_pkg;

  localparam int unsigned VRAM_AW   = 14;
  localparam int unsigned VRAM_DW   = 8;
  localparam int unsigned CRTC_MA_W = 14;
  localparam int unsigned CRTC_RA_W = 5;

  // Owner of the RAM port in a given clk; follows the access into the capture stage.
  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_VC,
    TAG_VA,
    TAG_CR,
    TAG_CW
  } slot_tag_e;

  // CRTC position as captured at a character tick.
  typedef struct packed {
    logic                 gfx;
    logic [CRTC_MA_W-1:0] ma;
    logic [CRTC_RA_W-1:0] ra;
  } crtc_pos_t;

endpackage

// File: rtl/cga_vram_addr_map.sv
// Maps a CRTC position plus byte select onto a VRAM byte address (text or CGA graphics layout).
module cga_vram_addr_map
  import cga_vram_pkg::*;
(
  input  logic                 gfx_mode,
  input  logic [CRTC_MA_W-1:0] crtc_ma,
  input  logic [CRTC_RA_W-1:0] crtc_ra,
  input  logic                 b,
  output logic [VRAM_AW-1:0]   vaddr_c
);

  logic unused_bits;
  assign unused_bits = ^{crtc_ma[CRTC_MA_W-1], crtc_ra[CRTC_RA_W-1:1]};

  // Graphics mode interleaves even/odd scanlines into the two 8 KB halves.
  always_comb begin
    if (gfx_mode) begin
      vaddr_c = {crtc_ra[0], crtc_ma[11:0], b};
    end else begin
      vaddr_c = {crtc_ma[12:0], b};
    end
  end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Single-port VRAM arbiter: CRTC char/attr fetch has absolute priority, the ISA CPU
// takes any free slot and is held off with cpu_wait until its access completes.
module cga_vram_arbiter
  import cga_vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW,
  parameter int unsigned DW = VRAM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 char_tick,
  input  logic                 gfx_mode,
  input  logic [CRTC_MA_W-1:0] crtc_ma,
  input  logic [CRTC_RA_W-1:0] crtc_ra,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_wait,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_we,
  output logic [DW-1:0]        ram_wdata,
  input  logic [DW-1:0]        ram_rdata,
  output logic [DW-1:0]        vid_char,
  output logic [DW-1:0]        vid_attr,
  output logic                 vid_valid,
  output logic                 overrun
);

  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        issued_q, issued_d;
  logic        attr_pend_q, attr_pend_d;
  crtc_pos_t   pos_q, pos_d;
  slot_tag_e   tag_q, tag_d;
  logic [DW-1:0] stage_q, stage_d;
  logic [DW-1:0] vid_char_q, vid_char_d;
  logic [DW-1:0] vid_attr_q, vid_attr_d;
  logic        vid_valid_q, vid_valid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        overrun_q, overrun_d;

  crtc_pos_t          live_pos;
  crtc_pos_t          map_pos;
  logic               map_b;
  logic [VRAM_AW-1:0] vaddr_c;
  slot_tag_e          issue_tag;

  assign live_pos = {gfx_mode, crtc_ma, crtc_ra};

  // The attr fetch reuses the position captured at the tick, unless a new tick pre-empts it.
  always_comb begin
    map_pos = live_pos;
    map_b   = 1'b0;
    if (!char_tick && attr_pend_q) begin
      map_pos = pos_q;
      map_b   = 1'b1;
    end
  end

  cga_vram_addr_map u_addr_map (
    .gfx_mode (map_pos.gfx),
    .crtc_ma  (map_pos.ma),
    .crtc_ra  (map_pos.ra),
    .b        (map_b),
    .vaddr_c  (vaddr_c)
  );

  // Port owner for this clk; the CPU only sees the request one clk after it is sampled.
  always_comb begin
    issue_tag = TAG_NONE;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!reset) begin
      if (char_tick) begin
        issue_tag = TAG_VC;
        ram_addr  = AW'(vaddr_c);
      end else if (attr_pend_q) begin
        issue_tag = TAG_VA;
        ram_addr  = AW'(vaddr_c);
      end else if (req_q && !done_q && !issued_q) begin
        issue_tag = cpu_we ? TAG_CW : TAG_CR;
        ram_addr  = cpu_addr;
        if (cpu_we) begin
          ram_we    = 1'b1;
          ram_wdata = cpu_wdata;
        end
      end
    end
  end

  // Next-state: issue bookkeeping plus the capture stage driven by last clk's tag.
  always_comb begin
    req_d       = cpu_req;
    done_d      = done_q;
    issued_d    = issued_q;
    attr_pend_d = attr_pend_q;
    pos_d       = pos_q;
    tag_d       = issue_tag;
    stage_d     = stage_q;
    vid_char_d  = vid_char_q;
    vid_attr_d  = vid_attr_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    overrun_d   = overrun_q;

    if (char_tick) begin
      attr_pend_d = 1'b1;
      pos_d       = live_pos;
      if (attr_pend_q) begin
        overrun_d = 1'b1;
      end
    end else if (attr_pend_q) begin
      attr_pend_d = 1'b0;
    end

    if (issue_tag == TAG_CR || issue_tag == TAG_CW) begin
      issued_d = 1'b1;
    end

    case (tag_q)
      TAG_VC: stage_d = ram_rdata;
      TAG_VA: begin
        vid_char_d  = stage_q;
        vid_attr_d  = ram_rdata;
        vid_valid_d = 1'b1;
      end
      TAG_CR: begin
        cpu_rdata_d = ram_rdata;
        cpu_ack_d   = 1'b1;
        done_d      = 1'b1;
        issued_d    = 1'b0;
      end
      TAG_CW: begin
        cpu_ack_d = 1'b1;
        done_d    = 1'b1;
        issued_d  = 1'b0;
      end
      default: ;
    endcase

    if (!cpu_req) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= 1'b0;
      attr_pend_q <= 1'b0;
      pos_q       <= '0;
      tag_q       <= TAG_NONE;
      stage_q     <= '0;
      vid_char_q  <= '0;
      vid_attr_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      req_q       <= req_d;
      done_q      <= done_d;
      issued_q    <= issued_d;
      attr_pend_q <= attr_pend_d;
      pos_q       <= pos_d;
      tag_q       <= tag_d;
      stage_q     <= stage_d;
      vid_char_q  <= vid_char_d;
      vid_attr_q  <= vid_attr_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_wait  = cpu_req & ~done_q;
  assign vid_char  = vid_char_q;
  assign vid_attr  = vid_attr_q;
  assign vid_valid = vid_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a queue scoreboard on vid_valid and cpu_ack.
module tb_cga_vram_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic          char_tick;
  logic          gfx_mode;
  logic [13:0]   crtc_ma;
  logic [4:0]    crtc_ra;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] vid_char;
  logic [DW-1:0] vid_attr;
  logic          vid_valid;
  logic          overrun;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [15:0]   vid_q [$];
  logic [7:0]    cpu_q [$];
  int            checks;
  int            failures;

  cga_vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .char_tick (char_tick),
    .gfx_mode  (gfx_mode),
    .crtc_ma   (crtc_ma),
    .crtc_ra   (crtc_ra),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_wait  (cpu_wait),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .vid_char  (vid_char),
    .vid_attr  (vid_attr),
    .vid_valid (vid_valid),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the clk after the address.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    logic [15:0] ve;
    logic [7:0]  ce;
    if (vid_valid === 1'b1) begin
      if (vid_q.size() == 0) begin
        chk("vid_unexpected", 32'(vid_valid), 32'h0);
      end else begin
        ve = vid_q.pop_front();
        chk("vid_char", 32'(vid_char), 32'(ve[15:8]));
        chk("vid_attr", 32'(vid_attr), 32'(ve[7:0]));
      end
    end
    if (cpu_ack === 1'b1) begin
      if (cpu_q.size() == 0) begin
        chk("ack_unexpected", 32'(cpu_ack), 32'h0);
      end else begin
        ce = cpu_q.pop_front();
        chk("cpu_rdata", 32'(cpu_rdata), 32'(ce));
      end
    end
  end

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_ack !== 1'b1 && n < 12);
    chk(name, 32'(cpu_ack), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    char_tick = 1'b0;
    gfx_mode  = 1'b0;
    crtc_ma   = '0;
    crtc_ra   = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7);
    mem[14'h0246] = 8'h41; mem[14'h0247] = 8'h1F;
    mem[14'h3578] = 8'hC3; mem[14'h3579] = 8'h3C;
    mem[14'h1000] = 8'h5A;
    mem[14'h0400] = 8'h11; mem[14'h0401] = 8'h22;
    mem[14'h0602] = 8'h33; mem[14'h0603] = 8'h44;
    mem[14'h2000] = 8'h99;

    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_ack",   32'(cpu_ack),   32'h0);
    chk("rst_vld",   32'(vid_valid), 32'h0);
    chk("rst_ovr",   32'(overrun),   32'h0);
    chk("rst_we",    32'(ram_we),    32'h0);
    chk("rst_wait",  32'(cpu_wait),  32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // Text fetch; crtc_ma changes after the tick to prove the attr uses the captured value.
    @(negedge clk);
    char_tick = 1'b1; gfx_mode = 1'b0; crtc_ma = 14'h0123; crtc_ra = 5'd0;
    vid_q.push_back({8'h41, 8'h1F});
    #2 chk("txt_vc_addr", 32'(ram_addr), 32'h0246);
    chk("txt_vc_we", 32'(ram_we), 32'h0);
    @(negedge clk); char_tick = 1'b0; crtc_ma = 14'h0555;
    #2 chk("txt_va_addr", 32'(ram_addr), 32'h0247);
    @(negedge clk); #2 chk("txt_vld_early", 32'(vid_valid), 32'h0);
    @(negedge clk); #2 chk("txt_vld", 32'(vid_valid), 32'h1);
    repeat (3) @(negedge clk);

    // Graphics mapping.
    @(negedge clk);
    char_tick = 1'b1; gfx_mode = 1'b1; crtc_ma = 14'h0ABC; crtc_ra = 5'd1;
    vid_q.push_back({8'hC3, 8'h3C});
    #2 chk("gfx_vc_addr", 32'(ram_addr), 32'h3578);
    @(negedge clk); char_tick = 1'b0; crtc_ra = 5'd0; gfx_mode = 1'b0;
    #2 chk("gfx_va_addr", 32'(ram_addr), 32'h3579);
    repeat (4) @(negedge clk);

    // CPU read on an idle port.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1000;
    cpu_q.push_back(8'h5A);
    #2 chk("rd_wait0", 32'(cpu_wait), 32'h1);
    chk("rd_we0", 32'(ram_we), 32'h0);
    @(negedge clk); #2 chk("rd_addr", 32'(ram_addr), 32'h1000);
    chk("rd_we", 32'(ram_we), 32'h0);
    @(negedge clk); #2 chk("rd_wait_pre", 32'(cpu_wait), 32'h1);
    chk("rd_ack_early", 32'(cpu_ack), 32'h0);
    @(negedge clk); #2 chk("rd_ack", 32'(cpu_ack), 32'h1);
    chk("rd_wait_post", 32'(cpu_wait), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2 chk("rd_no_reack", 32'(cpu_ack), 32'h0);
    end
    @(negedge clk); cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: write request arrives with a tick; video takes two slots first.
    @(negedge clk);
    char_tick = 1'b1; crtc_ma = 14'h0200;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'h77;
    vid_q.push_back({8'h11, 8'h22});
    cpu_q.push_back(8'h5A);
    #2 chk("cw_vc_addr", 32'(ram_addr), 32'h0400);
    @(negedge clk); char_tick = 1'b0;
    #2 chk("cw_va_addr", 32'(ram_addr), 32'h0401);
    chk("cw_va_we", 32'(ram_we), 32'h0);
    @(negedge clk); #2 chk("cw_addr", 32'(ram_addr), 32'h0010);
    chk("cw_we", 32'(ram_we), 32'h1);
    chk("cw_wdata", 32'(ram_wdata), 32'h77);
    @(negedge clk); #2 chk("cw_we_off", 32'(ram_we), 32'h0);
    chk("cw_ack_early", 32'(cpu_ack), 32'h0);
    @(negedge clk); #2 chk("cw_ack", 32'(cpu_ack), 32'h1);
    @(negedge clk); cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 14'h0010;
    cpu_q.push_back(8'h77);
    wait_ack("rb_ack");
    @(negedge clk); cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Two back-to-back ticks: first char's attr fetch is pre-empted.
    @(negedge clk);
    char_tick = 1'b1; crtc_ma = 14'h0300;
    #2 chk("ovr_clear", 32'(overrun), 32'h0);
    chk("ovr_vc1", 32'(ram_addr), 32'h0600);
    @(negedge clk); crtc_ma = 14'h0301;
    vid_q.push_back({8'h33, 8'h44});
    #2 chk("ovr_vc2", 32'(ram_addr), 32'h0602);
    @(negedge clk); char_tick = 1'b0;
    #2 chk("ovr_va2", 32'(ram_addr), 32'h0603);
    chk("ovr_set", 32'(overrun), 32'h1);
    repeat (4) @(negedge clk);
    #2 chk("ovr_sticky", 32'(overrun), 32'h1);

    // Reset lands in the clk a CPU read is issued.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    @(negedge clk);
    #1 chk("rst_mid_issue", 32'(ram_addr), 32'h2000);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #2 chk("rm_ack",   32'(cpu_ack),   32'h0);
    chk("rm_rdata",    32'(cpu_rdata), 32'h0);
    chk("rm_char",     32'(vid_char),  32'h0);
    chk("rm_attr",     32'(vid_attr),  32'h0);
    chk("rm_ovr",      32'(overrun),   32'h0);
    chk("rm_addr",     32'(ram_addr),  32'h0);
    chk("rm_wait",     32'(cpu_wait),  32'h1);
    cpu_q.push_back(8'h99);
    @(negedge clk); #2 chk("rm_ack1", 32'(cpu_ack), 32'h0);
    chk("rm_reissue", 32'(ram_addr), 32'h2000);
    @(negedge clk); #2 chk("rm_ack2", 32'(cpu_ack), 32'h0);
    @(negedge clk); #2 chk("rm_ack3", 32'(cpu_ack), 32'h1);
    @(negedge clk); cpu_req = 1'b0;
    repeat (4) @(negedge clk);

    chk("vid_q_empty", 32'(vid_q.size()), 32'h0);
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
